stim_pulse_seq: RTL and testbench

Biphasic stimulation pulse-train sequencer for one stimulator front end. On a start request it drives a channel select and the cathodic/anodic phase requests through phase 1, the interphase gap and phase 2. It then opens a charge-balance window and waits for the balance-complete flag, inserts an interpulse interval, and repeats for the programmed pulse count. It sits directly upstream of the charge-balance logic: it produces `CH`, `CAN_STI`, `ANO_STI` and `CB_ON`, and consumes `CB_OK`.

---
 rtl/stim_pulse_seq_if.sv | 44 ++++
 rtl/stim_pulse_seq.sv | 267 ++++++++++++++++++++++++++
 tb/tb_stim_pulse_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stim_pulse_seq_if.sv
// stim_pulse_seq_if
//   Groups the request, configuration, handshake and status signals of one
//   stimulation pulse-train sequencer.
//   master : system side. Drives START/ABORT, the train configuration
//            fields and CB_OK, and observes the sequencer outputs.
//   slave  : the sequencer itself.
//   Parameters CNT_W / NP_W must match those of the attached stim_pulse_seq.
interface stim_pulse_seq_if #(
  parameter int CNT_W = 8,
  parameter int NP_W  = 6
);
  // requests and train configuration
  logic             START;
  logic             ABORT;
  logic [1:0]       CH_IN;
  logic             POL_FIRST;
  logic [CNT_W-1:0] T_PH;
  logic [CNT_W-1:0] T_IPG;
  logic [CNT_W-1:0] T_IPI;
  logic [CNT_W-1:0] T_CB_MAX;
  logic [NP_W-1:0]  N_PULSE;
  // balance-complete flag from the charge-balance logic
  logic             CB_OK;
  // sequencer outputs
  logic [1:0]       CH;
  logic             CAN_STI;
  logic             ANO_STI;
  logic             CB_ON;
  logic             BUSY;
  logic             DONE;
  logic             CB_FAIL;

  modport master (
    output START, ABORT, CH_IN, POL_FIRST, T_PH, T_IPG, T_IPI, T_CB_MAX,
           N_PULSE, CB_OK,
    input  CH, CAN_STI, ANO_STI, CB_ON, BUSY, DONE, CB_FAIL
  );

  modport slave (
    input  START, ABORT, CH_IN, POL_FIRST, T_PH, T_IPG, T_IPI, T_CB_MAX,
           N_PULSE, CB_OK,
    output CH, CAN_STI, ANO_STI, CB_ON, BUSY, DONE, CB_FAIL
  );
endinterface

// File: rtl/stim_pulse_seq.sv
// stim_pulse_seq
//   Biphasic stimulation pulse-train sequencer for one stimulator front end.
//   Each pulse runs phase 1, interphase gap, phase 2, an optional
//   charge-balance window, then an interpulse interval; the train repeats
//   for the latched pulse count and ends with a one-cycle DONE.
//
// Ports
//   CLK  : system clock
//   RST  : synchronous, active-high reset
//   bus  : stim_pulse_seq_if.slave
//          in  START, ABORT, CH_IN, POL_FIRST, T_PH, T_IPG, T_IPI,
//              T_CB_MAX, N_PULSE, CB_OK
//          out CH, CAN_STI, ANO_STI, CB_ON, BUSY, DONE, CB_FAIL
//
// Build option
//   STIM_CB_SEQ_EN : when defined, a charge-balance window (CB state) follows
//                    phase 2. When undefined, phase 2 goes straight to the
//                    interpulse interval, CB_ON and CB_FAIL are tied low and
//                    CB_OK / T_CB_MAX are not used.
//
// States
//   state | meaning
//   IDLE  | waiting for START, all phase outputs low
//   PH1   | first phase (polarity from POL_FIRST)
//   IPG   | interphase gap
//   PH2   | second phase (opposite polarity)
//   CB    | charge-balance window, CB_ON high (STIM_CB_SEQ_EN only)
//   IPI   | interpulse interval, CB_ON forced low
//
// All outputs are registered and decoded from the next state, so they change
// on the same edge as the state register.
module stim_pulse_seq #(
  parameter int CNT_W = 8,
  parameter int NP_W  = 6
) (
  input  logic            CLK,
  input  logic            RST,
  stim_pulse_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PH1  = 3'd1;
  localparam logic [2:0] S_IPG  = 3'd2;
  localparam logic [2:0] S_PH2  = 3'd3;
  localparam logic [2:0] S_IPI  = 3'd4;
`ifdef STIM_CB_SEQ_EN
  localparam logic [2:0] S_CB   = 3'd5;
`endif

  // Down-counter load value: a field of 0 behaves like 1, so every timed
  // state lasts at least one cycle.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NP_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0] tph_q, tph_d;
  logic [CNT_W-1:0] tipg_q, tipg_d;
  logic [CNT_W-1:0] tipi_q, tipi_d;
  logic             pol_q, pol_d;
  logic [1:0]       ch_q, ch_d;
  logic             can_q, can_d;
  logic             ano_q, ano_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef STIM_CB_SEQ_EN
  logic [CNT_W-1:0] tcb_q, tcb_d;
  logic             cbon_q, cbon_d;
  logic             cbfail_q, cbfail_d;
`endif

  logic cnt_zero;
  assign cnt_zero = (cnt_q == '0);

  // --------------------------------------------------------------------------
  // next-state, counters and latched configuration
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    tph_d    = tph_q;
    tipg_d   = tipg_q;
    tipi_d   = tipi_q;
    pol_d    = pol_q;
    ch_d     = ch_q;
    done_d   = 1'b0;
`ifdef STIM_CB_SEQ_EN
    tcb_d    = tcb_q;
    cbfail_d = cbfail_q;
`endif

    // ABORT outranks everything, including a START seen in IDLE; CH and
    // CB_FAIL keep their values.
    if (bus.ABORT) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            state_d  = S_PH1;
            tph_d    = bus.T_PH;
            tipg_d   = bus.T_IPG;
            tipi_d   = bus.T_IPI;
            pol_d    = bus.POL_FIRST;
            ch_d     = bus.CH_IN;
            cnt_d    = load_val(bus.T_PH);
            pcnt_d   = (bus.N_PULSE == '0) ? '0 : bus.N_PULSE - NP_W'(1);
`ifdef STIM_CB_SEQ_EN
            tcb_d    = bus.T_CB_MAX;
            cbfail_d = 1'b0;
`endif
          end
        end

        S_PH1: begin
          if (cnt_zero) begin
            state_d = S_IPG;
            cnt_d   = load_val(tipg_q);
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end

        S_IPG: begin
          if (cnt_zero) begin
            state_d = S_PH2;
            cnt_d   = load_val(tph_q);
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end

        S_PH2: begin
          if (cnt_zero) begin
`ifdef STIM_CB_SEQ_EN
            state_d = S_CB;
            cnt_d   = load_val(tcb_q);
`else
            state_d = S_IPI;
            cnt_d   = load_val(tipi_q);
`endif
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end

`ifdef STIM_CB_SEQ_EN
        S_CB: begin
          // CB_OK on the timeout cycle counts as success.
          if (bus.CB_OK) begin
            state_d  = S_IPI;
            cnt_d    = load_val(tipi_q);
          end else if (cnt_zero) begin
            state_d  = S_IPI;
            cnt_d    = load_val(tipi_q);
            cbfail_d = 1'b1;
          end else begin
            cnt_d    = cnt_q - CNT_W'(1);
          end
        end
`endif

        S_IPI: begin
          if (cnt_zero) begin
            if (pcnt_q == '0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_PH1;
              pcnt_d  = pcnt_q - NP_W'(1);
              cnt_d   = load_val(tph_q);
            end
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // output decode from the next state
  // --------------------------------------------------------------------------
  always_comb begin
    can_d  = ((state_d == S_PH1) && !pol_d) || ((state_d == S_PH2) && pol_d);
    ano_d  = ((state_d == S_PH1) && pol_d)  || ((state_d == S_PH2) && !pol_d);
    busy_d = (state_d != S_IDLE);
  end

`ifdef STIM_CB_SEQ_EN
  always_comb begin
    cbon_d = (state_d == S_CB);
  end
`endif

  // --------------------------------------------------------------------------
  // registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      tph_q    <= '0;
      tipg_q   <= '0;
      tipi_q   <= '0;
      pol_q    <= 1'b0;
      ch_q     <= 2'd0;
      can_q    <= 1'b0;
      ano_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      tph_q    <= tph_d;
      tipg_q   <= tipg_d;
      tipi_q   <= tipi_d;
      pol_q    <= pol_d;
      ch_q     <= ch_d;
      can_q    <= can_d;
      ano_q    <= ano_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef STIM_CB_SEQ_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      tcb_q    <= '0;
      cbon_q   <= 1'b0;
      cbfail_q <= 1'b0;
    end else begin
      tcb_q    <= tcb_d;
      cbon_q   <= cbon_d;
      cbfail_q <= cbfail_d;
    end
  end
`endif

  assign bus.CH      = ch_q;
  assign bus.CAN_STI = can_q;
  assign bus.ANO_STI = ano_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;

`ifdef STIM_CB_SEQ_EN
  assign bus.CB_ON   = cbon_q;
  assign bus.CB_FAIL = cbfail_q;
`else
  // Without the balance window the balance inputs are deliberately ignored.
  logic unused_cb;
  assign unused_cb   = ^{bus.CB_OK, bus.T_CB_MAX};
  assign bus.CB_ON   = 1'b0;
  assign bus.CB_FAIL = 1'b0;
`endif

endmodule

// File: tb/tb_stim_pulse_seq.sv
// tb_stim_pulse_seq
//   Testbench for stim_pulse_seq. For every train the bench writes out the
//   whole expected per-cycle output timeline from the train parameters
//   (phase widths, gap, balance outcome per pulse, interval, count) and
//   replays it, driving CB_OK / ABORT / RST from the same timeline and
//   scrambling START and the configuration fields while the train is busy.
module tb_stim_pulse_seq;
  localparam int CNT_W = 8;
  localparam int NP_W  = 6;
`ifdef STIM_CB_SEQ_EN
  localparam int CB = 1;
`else
  localparam int CB = 0;
`endif

  typedef struct packed {
    logic [1:0] ch;
    logic       can;
    logic       ano;
    logic       cbon;
    logic       busy;
    logic       done;
    logic       cbf;
  } out_t;

  typedef struct packed {
    out_t o;
    logic cbok;
    logic abort;
    logic rst;
  } ent_t;

  logic CLK;
  logic RST;
  int   checks   = 0;
  int   failures = 0;
  int   n_can = 0, n_ano = 0, n_cbon = 0, n_busy = 0, n_done = 0;
  logic [1:0] mdl_ch;
  logic       mdl_cbf;
  int   cb_delay [64];

  stim_pulse_seq_if #(.CNT_W(CNT_W), .NP_W(NP_W)) bus ();

  stim_pulse_seq #(.CNT_W(CNT_W), .NP_W(NP_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic out_t mk(input logic [1:0] ch, input logic can,
                              input logic ano, input logic cbon,
                              input logic busy, input logic done,
                              input logic cbf);
    out_t o;
    o.ch = ch; o.can = can; o.ano = ano; o.cbon = cbon;
    o.busy = busy; o.done = done; o.cbf = cbf;
    return o;
  endfunction

  function automatic ent_t ent(input out_t o, input logic cbok);
    ent_t e;
    e.o = o; e.cbok = cbok; e.abort = 1'b0; e.rst = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs mid-cycle.
  task automatic step(input ent_t e, input logic start_v);
    out_t act;
    RST       = e.rst;
    bus.ABORT = e.abort;
    bus.CB_OK = e.cbok;
    if (e.o.busy) begin
      bus.START     = 1'($urandom);
      bus.CH_IN     = 2'($urandom);
      bus.POL_FIRST = 1'($urandom);
      bus.T_PH      = CNT_W'($urandom);
      bus.T_IPG     = CNT_W'($urandom);
      bus.T_IPI     = CNT_W'($urandom);
      bus.T_CB_MAX  = CNT_W'($urandom);
      bus.N_PULSE   = NP_W'($urandom);
    end else begin
      bus.START = start_v;
    end
    @(negedge CLK);
    act = {bus.CH, bus.CAN_STI, bus.ANO_STI, bus.CB_ON, bus.BUSY, bus.DONE,
           bus.CB_FAIL};
    checks++;
    if (act !== e.o) begin
      failures++;
      $display("FAIL outputs t=%0t act ch=%0d can=%0b ano=%0b cbon=%0b busy=%0b done=%0b cbfail=%0b exp ch=%0d can=%0b ano=%0b cbon=%0b busy=%0b done=%0b cbfail=%0b",
               $time, act.ch, act.can, act.ano, act.cbon, act.busy, act.done,
               act.cbf, e.o.ch, e.o.can, e.o.ano, e.o.cbon, e.o.busy,
               e.o.done, e.o.cbf);
    end
    if (act.can)  n_can++;
    if (act.ano)  n_ano++;
    if (act.cbon) n_cbon++;
    if (act.busy) n_busy++;
    if (act.done) n_done++;
    @(posedge CLK);
    #1;
  endtask

  // Build the expected timeline of one train, then replay it.
  // abort_at / rst_at: timeline index of the cycle carrying ABORT / RST
  // (-1 for none).
  task automatic run_train(input int tph, input int tipg, input int tipi,
                           input int tcbmax, input int np, input logic pol,
                           input logic [1:0] chv, input int abort_at,
                           input int rst_at);
    int   eph, eipg, eipi, enp, ab;
    logic cbf;
    ent_t e;
    ent_t q[$];
`ifdef STIM_CB_SEQ_EN
    int   ecb, d, dur;
    ecb  = (tcbmax == 0) ? 1 : tcbmax;
`endif
    eph  = (tph  == 0) ? 1 : tph;
    eipg = (tipg == 0) ? 1 : tipg;
    eipi = (tipi == 0) ? 1 : tipi;
    enp  = (np   == 0) ? 1 : np;
    cbf  = 1'b0;

    for (int p = 0; p < enp; p++) begin
      repeat (eph)  q.push_back(ent(mk(chv, !pol, pol, 1'b0, 1'b1, 1'b0, cbf), 1'($urandom)));
      repeat (eipg) q.push_back(ent(mk(chv, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cbf), 1'($urandom)));
      repeat (eph)  q.push_back(ent(mk(chv, pol, !pol, 1'b0, 1'b1, 1'b0, cbf), 1'($urandom)));
`ifdef STIM_CB_SEQ_EN
      d   = cb_delay[p];
      dur = (d >= 1 && d <= ecb) ? d : ecb;
      for (int i = 1; i <= dur; i++)
        q.push_back(ent(mk(chv, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, cbf), (i == d)));
      if (!(d >= 1 && d <= ecb)) cbf = 1'b1;
      repeat (eipi) q.push_back(ent(mk(chv, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cbf), 1'($urandom)));
`else
      for (int i = 1; i <= eipi; i++)
        q.push_back(ent(mk(chv, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cbf), (i == cb_delay[p])));
`endif
    end
    q.push_back(ent(mk(chv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cbf), 1'($urandom)));

    ab = abort_at;
    if (ab >= 0) begin
      if (ab >= q.size() - 1) ab = -1;
      else if (q[ab].o.cbon) ab = -1;
    end
    if (ab >= 0) begin
      e = q[ab];
      e.abort = 1'b1;
      q[ab] = e;
      e = ent(mk(chv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, q[ab].o.cbf), 1'($urandom));
      while (q.size() > ab + 1) void'(q.pop_back());
      q.push_back(e);
    end else if (rst_at >= 0 && rst_at < q.size() - 1) begin
      e = q[rst_at];
      e.rst = 1'b1;
      q[rst_at] = e;
      while (q.size() > rst_at + 1) void'(q.pop_back());
      q.push_back(ent(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'($urandom)));
    end

    bus.T_PH      = CNT_W'(tph);
    bus.T_IPG     = CNT_W'(tipg);
    bus.T_IPI     = CNT_W'(tipi);
    bus.T_CB_MAX  = CNT_W'(tcbmax);
    bus.N_PULSE   = NP_W'(np);
    bus.POL_FIRST = pol;
    bus.CH_IN     = chv;
    step(ent(mk(mdl_ch, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mdl_cbf), 1'($urandom)), 1'b1);
    // first phase and BUSY must be up right after the accepting edge
    chk("start_busy", int'(bus.BUSY), 1);
    chk("start_phase", int'(pol ? bus.ANO_STI : bus.CAN_STI), 1);

    foreach (q[i]) step(q[i], 1'b0);
    mdl_ch  = q[q.size()-1].o.ch;
    mdl_cbf = q[q.size()-1].o.cbf;
  endtask

  // ABORT together with START while idle: nothing may start.
  task automatic idle_abort_start();
    ent_t e;
    e = ent(mk(mdl_ch, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mdl_cbf), 1'b0);
    e.abort   = 1'b1;
    bus.CH_IN = ~mdl_ch;
    bus.T_PH  = CNT_W'(3);
    step(e, 1'b1);
    step(ent(mk(mdl_ch, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mdl_cbf), 1'($urandom)), 1'b0);
    chk("abort_start_busy", int'(bus.BUSY), 0);
  endtask

  initial begin
    int b_can, b_ano, b_cbon, b_busy, b_done;
    ent_t e;
    RST = 1'b1;
    bus.START = 1'b0; bus.ABORT = 1'b0; bus.CH_IN = 2'd0; bus.POL_FIRST = 1'b0;
    bus.T_PH = '0; bus.T_IPG = '0; bus.T_IPI = '0; bus.T_CB_MAX = '0;
    bus.N_PULSE = '0; bus.CB_OK = 1'b0;
    mdl_ch = 2'd0; mdl_cbf = 1'b0;
    foreach (cb_delay[i]) cb_delay[i] = 0;
    @(posedge CLK);
    #1;
    e = ent(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    e.rst = 1'b1;
    step(e, 1'b0);
    step(ent(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0), 1'b0);

    // basic single pulse, CB_OK on the 3rd balance cycle
    b_can = n_can; b_ano = n_ano; b_cbon = n_cbon; b_busy = n_busy; b_done = n_done;
    cb_delay[0] = 3;
    run_train(3, 2, 2, 10, 1, 1'b0, 2'd2, -1, -1);
    chk("t1_can",  n_can  - b_can,  3);
    chk("t1_ano",  n_ano  - b_ano,  3);
    chk("t1_cbon", n_cbon - b_cbon, 3 * CB);
    chk("t1_busy", n_busy - b_busy, 10 + 3 * CB);
    chk("t1_done", n_done - b_done, 1);
    chk("t1_ch",   int'(bus.CH), 2);

    // balance timeout
    b_cbon = n_cbon; b_done = n_done;
    cb_delay[0] = 0;
    run_train(2, 1, 2, 10, 1, 1'b0, 2'd1, -1, -1);
    chk("t2_cbon",    n_cbon - b_cbon, 10 * CB);
    chk("t2_cb_fail", int'(bus.CB_FAIL), CB);
    chk("t2_done",    n_done - b_done, 1);

    // three pulses, anodic first
    b_can = n_can; b_ano = n_ano; b_cbon = n_cbon; b_done = n_done;
    cb_delay[0] = 2; cb_delay[1] = 5; cb_delay[2] = 1;
    run_train(2, 1, 4, 6, 3, 1'b1, 2'd3, -1, -1);
    chk("t3_can",  n_can  - b_can,  6);
    chk("t3_ano",  n_ano  - b_ano,  6);
    chk("t3_cbon", n_cbon - b_cbon, 8 * CB);
    chk("t3_done", n_done - b_done, 1);

    // ABORT in the 2nd PH2 cycle, then a normal train
    b_done = n_done;
    cb_delay[0] = 2; cb_delay[1] = 2;
    run_train(3, 2, 2, 10, 2, 1'b0, 2'd1, 6, -1);
    chk("t4_done", n_done - b_done, 0);
    chk("t4_busy", int'(bus.BUSY), 0);
    b_done = n_done;
    cb_delay[0] = 1; cb_delay[1] = 2;
    run_train(2, 2, 1, 4, 2, 1'b1, 2'd0, -1, -1);
    chk("t4b_done", n_done - b_done, 1);

    idle_abort_start();

    // reset in the 2nd balance cycle (IPI without the balance window)
    cb_delay[0] = 0;
    run_train(2, 1, 3, 5, 1, 1'b0, 2'd3, -1, 6);
    chk("t6_rst_ch", int'(bus.CH), 0);

    // randomized trains
    for (int t = 0; t < 25; t++) begin
      int ab;
      for (int i = 0; i < 8; i++) cb_delay[i] = int'($urandom_range(0, 8));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
      run_train(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 4)), 1'($urandom), 2'($urandom),
                ab, -1);
      if ($urandom_range(0, 3) == 0) idle_abort_start();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
